// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   - Prefix and control byte constants.
//   - Frame-state enum used by the frame receiver.
//   - Width of one key-table entry ({ext, code}).
//   - Helper that identifies bytes the decoder drops silently.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    localparam int unsigned KEY_ENTRY_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_PAUSE) || (b == PS2_BAT) || (b == PS2_ACK) ||
               (b == PS2_ECHO)  || (b == PS2_RESEND);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-level link between the PS/2 frame receiver and the key decoder.
//   rx_byte    : last correctly received data byte
//   byte_valid : one-cycle strobe, rx_byte is new
//   frame_err  : one-cycle strobe on start/parity/stop/timeout error
// master = frame receiver, slave = key decoder.
interface ps2_key_decoder_if;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    modport master (output rx_byte, byte_valid, frame_err);
    modport slave  (input  rx_byte, byte_valid, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw PS/2 clock and data pins,
// detects falling clock edges and deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), with an inter-edge timeout.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   ps2_clk  : raw PS/2 clock pin
//   ps2_dat  : raw PS/2 data pin
//   rx       : byte / byte_valid / frame_err outputs (master modport)
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    ps2_key_decoder_if.master  rx
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    frame_state_t state;
    logic [7:0]   shreg;
    logic [2:0]   bit_cnt;
    logic         par;
    logic [TW-1:0] cnt;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    assign fall  = clk_prev & ~clk_s;

    // Synchronisers idle at the bus-high level so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            par           <= 1'b0;
            cnt           <= '0;
            rx.rx_byte    <= '0;
            rx.byte_valid <= 1'b0;
            rx.frame_err  <= 1'b0;
        end else begin
            rx.byte_valid <= 1'b0;
            rx.frame_err  <= 1'b0;
            if (fall) begin
                cnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            rx.frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= dat_s;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Odd parity over data+parity, and stop must be high.
                        if (dat_s && (^{shreg, par})) begin
                            rx.rx_byte    <= shreg;
                            rx.byte_valid <= 1'b1;
                        end else begin
                            rx.frame_err  <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state        <= ST_IDLE;
                    rx.frame_err <= 1'b1;
                    cnt          <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: receives frames via ps2_frame_rx, folds E0/F0
// prefixes into make/break events and tracks held state for a table of keys.
// Ports:
//   vga_clk, reset : system clock, asynchronous active-high reset
//   PS2_CLK/PS2_DAT: raw PS/2 pins
//   keys_held      : bit i set while KEY_TABLE entry i is held
//   key_event      : one-cycle strobe per decoded make/break
//   key_code       : final scan-code byte of the event (held between events)
//   key_ext        : event had an E0 prefix
//   key_break      : event had an F0 prefix
//   frame_err      : one-cycle strobe on any frame error
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 6,
    // Entry 0 occupies the LSBs: up, left, down, right, 2B, 32.
    parameter logic [NUM_KEYS*KEY_ENTRY_W-1:0] KEY_TABLE =
        {9'h032, 9'h02B, 9'h174, 9'h172, 9'h16B, 9'h175},
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic                key_event,
    output logic [7:0]          key_code,
    output logic                key_ext,
    output logic                key_break,
    output logic                frame_err
);

    ps2_key_decoder_if rx_if ();

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clk     (vga_clk),
        .rst     (reset),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .rx      (rx_if.master)
    );

    logic ext;
    logic brk;

    assign frame_err = rx_if.frame_err;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_event <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            keys_held <= '0;
        end else begin
            key_event <= 1'b0;
            if (rx_if.frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_if.byte_valid) begin
                if (rx_if.rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rx_if.rx_byte == PS2_BRK) begin
                    brk <= 1'b1;
                end else if (is_discard(rx_if.rx_byte)) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    key_event <= 1'b1;
                    key_code  <= rx_if.rx_byte;
                    key_ext   <= ext;
                    key_break <= brk;
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                    // Duplicate entries match together; repeats are idempotent.
                    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                        if (KEY_TABLE[i*KEY_ENTRY_W +: KEY_ENTRY_W] == {ext, rx_if.rx_byte})
                            keys_held[i] <= !brk;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 5000;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [5:0] keys_held;
    logic       key_event;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       frame_err;

    ps2_key_decoder #(
        .NUM_KEYS       (6),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (2)
    ) dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keys_held (keys_held),
        .key_event (key_event),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .frame_err (frame_err)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [5:0] held;
        int         at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit         m_ext  = 0;
    bit         m_brk  = 0;
    logic [5:0] m_held = '0;
    logic [8:0] tbl [6] = '{9'h175, 9'h16B, 9'h172, 9'h174, 9'h02B, 9'h032};

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.is_err = 1; e.code = '0; e.ext = 0; e.brk = 0; e.held = m_held; e.at_cyc = at;
        m_ext = 0; m_brk = 0;
        exp_q.push_back(e);
    endtask

    // Reference behaviour of one received byte; fc = cycle of the stop-bit fall.
    task automatic model_byte(input logic [7:0] b, input bit bad, input int fc);
        exp_t e;
        if (bad) begin
            push_err(fc + 3);
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
            m_ext = 0; m_brk = 0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (tbl[i] == {m_ext, b}) m_held[i] = !m_brk;
            e.is_err = 0; e.code = b; e.ext = m_ext; e.brk = m_brk;
            e.held = m_held; e.at_cyc = fc + 4;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic ps2_bit(input logic b, output int fall_cyc);
        PS2_DAT = b;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        fall_cyc = cyc;
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        int   fc;
        logic p;
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], fc);
        ps2_bit(p, fc);
        PS2_DAT = 1'b1;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        model_byte(b, bad_par, cyc);
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            if (reset) continue;
            if (key_event || frame_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: key_event=%0b frame_err=%0b code=%h, expected no strobe",
                             key_event, frame_err, key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        if ({frame_err, key_event} !== 2'b10) begin
                            errors++;
                            $display("FAIL frame_err_strobe: frame_err=%0b key_event=%0b, expected 1/0",
                                     frame_err, key_event);
                        end
                    end else begin
                        if ({key_event, frame_err, key_code, key_ext, key_break, keys_held} !==
                            {1'b1, 1'b0, e.code, e.ext, e.brk, e.held}) begin
                            errors++;
                            $display("FAIL key_event_fields: got ev=%0b err=%0b code=%h ext=%0b brk=%0b held=%b, expected ev=1 err=0 code=%h ext=%0b brk=%0b held=%b",
                                     key_event, frame_err, key_code, key_ext, key_break, keys_held,
                                     e.code, e.ext, e.brk, e.held);
                        end
                    end
                    if (e.at_cyc >= 0) begin
                        checks++;
                        if (cyc != e.at_cyc) begin
                            errors++;
                            $display("FAIL strobe_latency: got cycle %0d, expected cycle %0d", cyc, e.at_cyc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        wait_cyc(3);
        checks++;
        if ({keys_held, key_event, key_code, key_ext, key_break, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got held=%b ev=%0b code=%h ext=%0b brk=%0b err=%0b, expected all 0",
                     keys_held, key_event, key_code, key_ext, key_break, frame_err);
        end
        reset = 1'b0;
        wait_cyc(10);
        checks++;
        if ({keys_held, key_event, frame_err} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got held=%b ev=%0b err=%0b, expected 0", keys_held, key_event, frame_err);
        end
    endtask

    task automatic test_plain_make();
        send_byte(8'h1C, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b000000) begin
            errors++;
            $display("FAIL plain_make: pending=%0d held=%b, expected 0 pending held=000000", exp_q.size(), keys_held);
        end
    endtask

    task automatic test_ext_make_break();
        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b000001) begin
            errors++;
            $display("FAIL ext_make: pending=%0d held=%b, expected 0 pending held=000001", exp_q.size(), keys_held);
        end
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b000000) begin
            errors++;
            $display("FAIL ext_break: pending=%0d held=%b, expected 0 pending held=000000", exp_q.size(), keys_held);
        end
    endtask

    task automatic test_bad_parity();
        send_byte(8'h2B, 1);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held[4] !== 1'b0) begin
            errors++;
            $display("FAIL bad_parity: pending=%0d held[4]=%b, expected 0 pending held[4]=0", exp_q.size(), keys_held[4]);
        end
        send_byte(8'h2B, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b010000) begin
            errors++;
            $display("FAIL after_bad_parity: pending=%0d held=%b, expected 0 pending held=010000", exp_q.size(), keys_held);
        end
    endtask

    task automatic test_start_err();
        PS2_DAT = 1'b1;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        push_err(cyc + 3);
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL start_err: pending=%0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_discard_and_repeat();
        send_byte(8'hE0, 0);
        send_byte(8'hFA, 0);
        send_byte(8'h75, 0);
        send_byte(8'h2B, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b010000) begin
            errors++;
            $display("FAIL discard_repeat: pending=%0d held=%b, expected 0 pending held=010000", exp_q.size(), keys_held);
        end
    endtask

    task automatic test_timeout();
        int fc;
        ps2_bit(1'b0, fc);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, fc);
        push_err(fc + TIMEOUT + 3);
        wait_cyc(TIMEOUT + 100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: pending=%0d, expected 0", exp_q.size());
        end
        send_byte(8'h32, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b110000) begin
            errors++;
            $display("FAIL after_timeout: pending=%0d held=%b, expected 0 pending held=110000", exp_q.size(), keys_held);
        end
    endtask

    task automatic test_prefix_cleared_by_err();
        send_byte(8'hE0, 0);
        send_byte(8'h11, 1);
        send_byte(8'h75, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held[0] !== 1'b0) begin
            errors++;
            $display("FAIL prefix_cleared: pending=%0d held[0]=%b, expected 0 pending held[0]=0", exp_q.size(), keys_held[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int fc;
        // Release 2B and 32 so only entries 0 and 1 end up held.
        send_byte(8'hF0, 0); send_byte(8'h2B, 0);
        send_byte(8'hF0, 0); send_byte(8'h32, 0);
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        wait_cyc(10);
        checks++;
        if (keys_held !== 6'b000011) begin
            errors++;
            $display("FAIL pre_reset_held: got %b, expected 000011", keys_held);
        end
        ps2_bit(1'b0, fc);
        ps2_bit(1'b1, fc);
        ps2_bit(1'b0, fc);
        reset = 1'b1;
        #1;
        checks++;
        if ({keys_held, key_event, key_code, key_ext, key_break, frame_err} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got held=%b ev=%0b code=%h ext=%0b brk=%0b err=%0b, expected all 0",
                     keys_held, key_event, key_code, key_ext, key_break, frame_err);
        end
        m_held = '0; m_ext = 0; m_brk = 0;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(10);
        send_byte(8'hF0, 0);
        send_byte(8'h2B, 0);
        wait_cyc(10);
        checks++;
        if (exp_q.size() != 0 || keys_held !== 6'b000000) begin
            errors++;
            $display("FAIL break_after_reset: pending=%0d held=%b, expected 0 pending held=000000", exp_q.size(), keys_held);
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #5ms;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_plain_make();
        test_ext_make_break();
        test_bad_parity();
        test_start_err();
        test_discard_and_repeat();
        test_timeout();
        test_prefix_cleared_by_err();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
